// File: rtl/mat_pkg.sv
// mat_pkg: shared widths, FSM state type and slot indices
// for the 2x2 matrix multiplier driver.
package mat_pkg;

    localparam int DW    = 16;
    localparam int RW    = 2 * DW;
    localparam int N_OPS = 8;
    localparam int N_RES = 4;

    // Last operand slot (h) and last result slot (z)
    localparam logic [2:0] OP_LAST  = 3'd7;
    localparam logic [1:0] RES_LAST = 2'd3;

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT,
        SEND
    } state_t;

endpackage

// File: rtl/mat_mult_driver_if.sv
// mat_mult_driver_if: operand stream, result stream and
// multiplier bus of the matrix multiplier driver.
interface mat_mult_driver_if #(
    parameter int DW = 16
);

    logic                       in_valid;
    logic                       in_ready;
    logic signed [DW-1:0]       in_data;

    logic                       out_valid;
    logic                       out_ready;
    logic signed [2*DW-1:0]     out_data;
    logic                       out_last;

    logic                       mm_start;
    logic        [8*DW-1:0]     mm_op;
    logic                       mm_done;
    logic        [8*DW-1:0]     mm_res;

    modport master (
        input  in_valid, in_data, out_ready, mm_done, mm_res,
        output in_ready, out_valid, out_data, out_last,
        output mm_start, mm_op
    );

    modport slave (
        output in_valid, in_data, out_ready, mm_done, mm_res,
        input  in_ready, out_valid, out_data, out_last,
        input  mm_start, mm_op
    );

endinterface

// File: rtl/mat_res_serializer.sv
// mat_res_serializer: holds the four results and presents them
// as a w,x,y,z stream with valid/ready hold and a z-beat last flag.
module mat_res_serializer #(
    parameter int RW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [4*RW-1:0]      res,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [RW-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);
    import mat_pkg::*;

    logic [N_RES-1:0][RW-1:0] res_q;
    logic [1:0]               res_cnt;
    logic                     fire;

    assign fire     = out_valid && out_ready;
    // res_q[3] holds w, so beat k reads slot 3-k
    assign out_data = res_q[RES_LAST - res_cnt];
    assign out_last = out_valid && (res_cnt == RES_LAST);
    assign done     = fire && out_last;

    // result register and beat counter; drops valid after z
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q     <= '0;
            res_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            res_q     <= res;
            res_cnt   <= '0;
            out_valid <= 1'b1;
        end else if (fire) begin
            res_cnt <= res_cnt + 2'd1;
            if (res_cnt == RES_LAST) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mat_mult_driver.sv
// mat_mult_driver: loads eight operands, fires the 2x2 multiplier and
// streams back four results. Optional WAIT watchdog: MAT_DRV_TIMEOUT_EN.
module mat_mult_driver #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mat_mult_driver_if.master bus,
    output logic              busy,
    output logic              err
);
    import mat_pkg::*;

    state_t                   state;
    state_t                   state_nx;
    logic [2:0]               op_cnt;
    logic [N_OPS-1:0][DW-1:0] ops;
    logic                     in_fire;
    logic                     load_res;
    logic                     ser_done;

    assign in_fire      = bus.in_valid && bus.in_ready;
    assign bus.in_ready = (state == LOAD);
    assign bus.mm_start = (state == FIRE);
    // ops[7] holds a, so the packed vector has a in the MSBs
    assign bus.mm_op    = ops;
    assign busy         = (state != LOAD);

    // operand capture; ops only change in LOAD so mm_op stays stable
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_cnt <= '0;
            ops    <= '0;
        end else if (in_fire) begin
            ops[OP_LAST - op_cnt] <= bus.in_data;
            op_cnt                <= op_cnt + 3'd1;
        end
    end

`ifdef MAT_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_cnt;
    logic          expired;

    assign expired = (state == WAIT) && !bus.mm_done &&
                     (wait_cnt == T_END);

    // counts cycles spent in WAIT, cleared elsewhere
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // sticky watchdog flag, cleared by the next accepted operand
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (expired) begin
            err <= 1'b1;
        end else if (in_fire) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // next state; mm_done only matters in WAIT
    always_comb begin
        state_nx = state;
        load_res = 1'b0;
        unique case (state)
            LOAD: begin
                if (in_fire && (op_cnt == OP_LAST)) begin
                    state_nx = FIRE;
                end
            end
            FIRE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.mm_done) begin
                    load_res = 1'b1;
                    state_nx = SEND;
                end
`ifdef MAT_DRV_TIMEOUT_EN
                else if (expired) begin
                    state_nx = LOAD;
                end
`endif
            end
            SEND: begin
                if (ser_done) begin
                    state_nx = LOAD;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    mat_res_serializer #(
        .RW (2 * DW)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load_res),
        .res       (bus.mm_res),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_mat_mult_driver.sv
// tb_mat_mult_driver: randomized bench for mat_mult_driver with a
// behavioural 2x2 multiplier and a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mat_mult_driver;

    localparam int DW      = 16;
    localparam int RW      = 32;
    localparam int TIMEOUT = 15;

    typedef logic signed [DW-1:0] op_arr_t [8];
    typedef logic signed [RW-1:0] res_arr_t [4];

    logic            clk = 1'b0;
    logic            reset;
    logic            busy;
    logic            err;
    int              n_tests = 0;
    int              n_fail  = 0;
    bit              mm_en    = 1'b1;
    int              mm_delay = 3;
    logic            mm_done_m = 1'b0;
    logic [4*RW-1:0] mm_res_m  = '0;
    logic            spur      = 1'b0;

    mat_mult_driver_if #(.DW(DW)) bus ();

    mat_mult_driver #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    assign bus.mm_done = mm_done_m | spur;
    assign bus.mm_res  = mm_res_m;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // [[a b][c d]] x [[e f][g h]] with 32-bit wrap
    function automatic res_arr_t ref_mm(input op_arr_t v);
        res_arr_t r;
        int a, b, c, d, e, f, g, h;
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        e = v[4]; f = v[5]; g = v[6]; h = v[7];
        r[0] = a * e + b * g;
        r[1] = a * f + b * h;
        r[2] = c * e + d * g;
        r[3] = c * f + d * h;
        return r;
    endfunction

    function automatic logic [8*DW-1:0] pack_ops(input op_arr_t v);
        logic [8*DW-1:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p = {p[7*DW-1:0], v[i]};
        return p;
    endfunction

    // behavioural multiplier: done pulse mm_delay cycles after start
    initial begin : mm_model
        logic [8*DW-1:0] snap;
        longint          m [8];
        forever begin
            @(negedge clk);
            if (mm_en && bus.mm_start === 1'b1) begin
                snap = bus.mm_op;
                for (int i = 0; i < 8; i++)
                    m[i] = longint'($signed(snap[(7-i)*DW +: DW]));
                mm_res_m = {32'(m[0]*m[4] + m[1]*m[6]),
                            32'(m[0]*m[5] + m[1]*m[7]),
                            32'(m[2]*m[4] + m[3]*m[6]),
                            32'(m[2]*m[5] + m[3]*m[7])};
                @(negedge clk);
                chk("start_once", bus.mm_start, 1'b0);
                repeat (mm_delay - 1) @(negedge clk);
                chk("mm_op_hold", bus.mm_op, snap);
                mm_done_m = 1'b1;
                @(negedge clk);
                mm_done_m = 1'b0;
                chk("lat_valid", bus.out_valid, 1'b1);
                chk("lat_w", bus.out_data, $signed(mm_res_m[127:96]));
            end
        end
    end

    task automatic send_ops(input op_arr_t v, input int max_gap,
                            output logic err_first);
        int n;
        err_first = 1'bx;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                chk("in_ready_wait", bus.in_ready, 1'b1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (i == 0) err_first = err;
        end
        bus.in_valid = 1'b0;
        chk("start_pulse", bus.mm_start, 1'b1);
        chk("mm_op_pack", bus.mm_op, pack_ops(v));
        chk("busy_fire", busy, 1'b1);
    endtask

    task automatic recv(input res_arr_t exp, input int stall_beat,
                        input int stall_n, input bit rand_bp);
        int n;
        int st;
        for (int b = 0; b < 4; b++) begin
            bus.out_ready = 1'b0;
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n >= 60) begin
                chk("out_valid_wait", bus.out_valid, 1'b1);
                return;
            end
            st = (b == stall_beat) ? stall_n :
                 (rand_bp ? int'($urandom_range(2, 0)) : 0);
            for (int k = 0; k < st; k++) begin
                chk("hold_data", bus.out_data, exp[b]);
                chk("hold_last", bus.out_last, (b == 3));
                @(negedge clk);
            end
            chk("out_data", bus.out_data, exp[b]);
            chk("out_last", bus.out_last, (b == 3));
            chk("no_in_ready", bus.in_ready, 1'b0);
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("done_valid", bus.out_valid, 1'b0);
        chk("done_ready", bus.in_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        op_arr_t  v;
        res_arr_t r;
        logic     e1;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_mm_start", bus.mm_start, 1'b0);
        chk("rst_mm_op", bus.mm_op, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 8; i++) v[i] = DW'(i + 1);
        mm_delay = 3;
        send_ops(v, 0, e1);
        r = '{32'sd19, 32'sd22, 32'sd43, 32'sd50};
        recv(r, -1, 0, 1'b0);

        for (int i = 0; i < 8; i++) v[i] = '0;
        v[0] = 16'sh8000;
        v[1] = 16'sh8000;
        v[4] = 16'sh8000;
        v[6] = 16'sh8000;
        send_ops(v, 1, e1);
        r = '{32'sh80000000, 32'sd0, 32'sd0, 32'sd0};
        recv(r, -1, 0, 1'b0);

        for (int i = 0; i < 8; i++) v[i] = DW'(i + 1);
        send_ops(v, 0, e1);
        r = '{32'sd19, 32'sd22, 32'sd43, 32'sd50};
        recv(r, 1, 3, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) v[i] = DW'($urandom);
            mm_delay = $urandom_range(5, 1);
            send_ops(v, 2, e1);
            r = ref_mm(v);
            recv(r, -1, 0, 1'b1);
        end

        mm_en    = 1'b0;
        mm_delay = 3;
        for (int i = 0; i < 8; i++) v[i] = DW'($urandom);
        send_ops(v, 0, e1);
        repeat (2) @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_start", bus.mm_start, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        reset = 1'b1;
        spur  = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("spur_valid", bus.out_valid, 1'b0);
            chk("spur_busy", busy, 1'b0);
            @(negedge clk);
        end
        mm_en = 1'b1;
        for (int i = 0; i < 8; i++) v[i] = DW'($urandom);
        send_ops(v, 1, e1);
        r = ref_mm(v);
        recv(r, -1, 0, 1'b1);

`ifdef MAT_DRV_TIMEOUT_EN
        mm_en = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = DW'($urandom);
        send_ops(v, 0, e1);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            chk("to_busy", busy, 1'b1);
        end
        chk("to_err_early", err, 1'b0);
        @(negedge clk);
        chk("to_err", err, 1'b1);
        chk("to_in_ready", bus.in_ready, 1'b1);
        chk("to_no_valid", bus.out_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", err, 1'b1);
        chk("to_no_valid2", bus.out_valid, 1'b0);
        mm_en = 1'b1;
        for (int i = 0; i < 8; i++) v[i] = DW'($urandom);
        send_ops(v, 0, e1);
        chk("to_err_clear", e1, 1'b0);
        r = ref_mm(v);
        recv(r, -1, 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
